// File: rtl/data_demux_rx_2.sv
// data_demux_rx_2: Modbus read-response demultiplexer; collects a register block into shadow storage and commits it atomically to the outputs
//   clk, reset_n                  : clock, asynchronous active-low reset
//   rx_start, rx_adr, rx_first_reg: frame header pulse with slave address and first register
//   rx_valid, rx_data             : register word pulse and data
//   rx_end, rx_crc_ok             : end-of-frame pulse and CRC verdict
//   data_340_2 .. data_349_2      : committed register values
//   update                        : one-cycle pulse after each commit
//   link_ok                       : a commit happened within timeout_cycles
//   err_cnt                       : saturating count of rejected frames
module data_demux_rx_2 #(
   parameter logic [7:0]  slave_adr          = 8'd2,
   parameter logic [15:0] adr_first_reg_read = 16'd340,
   parameter int          num_reg_read       = 10,
   parameter logic [23:0] timeout_cycles     = 24'd5_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_start,
   input  logic [7:0]  rx_adr,
   input  logic [15:0] rx_first_reg,
   input  logic        rx_valid,
   input  logic [15:0] rx_data,
   input  logic        rx_end,
   input  logic        rx_crc_ok,
   output logic [15:0] data_340_2,
   output logic [15:0] data_341_2,
   output logic [15:0] data_342_2,
   output logic [15:0] data_343_2,
   output logic [15:0] data_344_2,
   output logic [15:0] data_345_2,
   output logic [15:0] data_346_2,
   output logic [15:0] data_347_2,
   output logic [15:0] data_348_2,
   output logic [15:0] data_349_2,
   output logic        update,
   output logic        link_ok,
   output logic [7:0]  err_cnt
);
   localparam logic [3:0] N = 4'(num_reg_read);
   typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d, crc_q, crc_d;
   logic [15:0] shadow_q [10];
   logic [15:0] shadow_d [10];
   logic [15:0] data_q [10];
   logic [15:0] data_d [10];
   logic        update_q, update_d, link_q, link_d;
   logic [7:0]  err_q, err_d;
   logic [23:0] tmo_q, tmo_d;
   logic        hdr_ok, commit, err_inc;
   assign hdr_ok = rx_start && rx_adr == slave_adr && rx_first_reg == adr_first_reg_read;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      crc_d    = crc_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      commit   = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (hdr_ok) begin
               state_d = COLLECT;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         COLLECT: begin
            // a new header aborts the frame in progress and is evaluated immediately
            if (rx_start) begin
               err_inc = 1'b1;
               state_d = hdr_ok ? COLLECT : IDLE;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end else begin
               if (rx_valid) begin
                  if (cnt_q < N) begin
                     for (int k = 0; k < 10; k++)
                        if (cnt_q == 4'(k)) shadow_d[k] = rx_data;
                     cnt_d = cnt_q + 4'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               if (rx_end) begin
                  state_d = CHECK;
                  crc_d   = rx_crc_ok;
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
            commit  = crc_q && cnt_q == N && !ovf_q;
            err_inc = !commit;
         end
         default: state_d = IDLE;
      endcase
      if (commit)
         for (int k = 0; k < num_reg_read; k++) data_d[k] = shadow_q[k];
   end
   assign update_d = commit;
   assign err_d    = err_inc && err_q != 8'hFF ? err_q + 8'd1 : err_q;
   assign tmo_d    = commit ? '0 : tmo_q == timeout_cycles ? tmo_q : tmo_q + 24'd1;
   // a commit in the saturation cycle keeps the link up
   assign link_d   = commit ? 1'b1 : tmo_d == timeout_cycles ? 1'b0 : link_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         crc_q    <= 1'b0;
         shadow_q <= '{default: '0};
         data_q   <= '{default: '0};
         update_q <= 1'b0;
         link_q   <= 1'b0;
         err_q    <= '0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         crc_q    <= crc_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         update_q <= update_d;
         link_q   <= link_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end
   assign data_340_2 = data_q[0];
   assign data_341_2 = data_q[1];
   assign data_342_2 = data_q[2];
   assign data_343_2 = data_q[3];
   assign data_344_2 = data_q[4];
   assign data_345_2 = data_q[5];
   assign data_346_2 = data_q[6];
   assign data_347_2 = data_q[7];
   assign data_348_2 = data_q[8];
   assign data_349_2 = data_q[9];
   assign update     = update_q;
   assign link_ok    = link_q;
   assign err_cnt    = err_q;
endmodule

// File: tb/tb_data_demux_rx_2.sv
// tb_data_demux_rx_2: scoreboard bench for data_demux_rx_2
module tb_data_demux_rx_2;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_start = 1'b0, rx_valid = 1'b0, rx_end = 1'b0, rx_crc_ok = 1'b0;
   logic [7:0]  rx_adr = '0;
   logic [15:0] rx_first_reg = '0, rx_data = '0;
   logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9;
   logic        update, link_ok;
   logic [7:0]  err_cnt;
   logic [159:0] dout, cur;
   logic [159:0] exp_q [$];
   logic        prev_upd = 1'b0;
   int          checks = 0, errors = 0;

   data_demux_rx_2 #(.timeout_cycles(24'd100)) dut (
      .clk(clk), .reset_n(reset_n), .rx_start(rx_start), .rx_adr(rx_adr),
      .rx_first_reg(rx_first_reg), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_end(rx_end), .rx_crc_ok(rx_crc_ok),
      .data_340_2(d0), .data_341_2(d1), .data_342_2(d2), .data_343_2(d3), .data_344_2(d4),
      .data_345_2(d5), .data_346_2(d6), .data_347_2(d7), .data_348_2(d8), .data_349_2(d9),
      .update(update), .link_ok(link_ok), .err_cnt(err_cnt));

   assign dout = {d9, d8, d7, d6, d5, d4, d3, d2, d1, d0};
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every update pulse must match the oldest expected commit
   always @(negedge clk) begin
      if (update === 1'b1) begin
         check("update_one_cycle", 160'(prev_upd), 160'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update: got update=1 expected no commit");
         end else begin
            check("commit_data", dout, exp_q.pop_front());
         end
      end
      prev_upd = update;
   end

   task automatic pulse(input logic s, input logic v, input logic e, input logic crc,
                        input logic [7:0] adr, input logic [15:0] fr, input logic [15:0] d);
      rx_start = s; rx_valid = v; rx_end = e; rx_crc_ok = crc;
      rx_adr = adr; rx_first_reg = fr; rx_data = d;
      @(negedge clk);
      rx_start = 1'b0; rx_valid = 1'b0; rx_end = 1'b0;
   endtask

   task automatic push_exp(input logic [15:0] base);
      logic [159:0] v;
      for (int k = 0; k < 10; k++) v[k*16 +: 16] = base + 16'(k);
      exp_q.push_back(v);
      cur = v;
   endtask

   // header, n words, end; merge puts rx_end on the last word; ends one negedge after the commit edge
   task automatic frame(input logic [7:0] adr, input logic [15:0] fr, input int n,
                        input logic [15:0] base, input logic crc, input logic commit,
                        input logic merge);
      if (commit) push_exp(base);
      pulse(1, 0, 0, 0, adr, fr, 0);
      for (int i = 0; i < n; i++)
         pulse(0, 1, merge && i == n - 1, crc, 0, 0, base + 16'(i));
      if (!merge) pulse(0, 0, 1, crc, 0, 0, 0);
      pulse(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      cur = '0;
      repeat (3) @(negedge clk);
      check("reset_data", dout, '0);
      check("reset_update", 160'(update), 160'd0);
      check("reset_link", 160'(link_ok), 160'd0);
      check("reset_err", 160'(err_cnt), 160'd0);
      reset_n = 1'b1;
      @(negedge clk);
      frame(2, 340, 10, 16'h0001, 1, 1, 0);
      check("good_link", 160'(link_ok), 160'd1);
      check("good_err", 160'(err_cnt), 160'd0);
      check("good_data", dout, cur);
      frame(2, 340, 10, 16'h0011, 0, 0, 0);
      check("crc_err", 160'(err_cnt), 160'd1);
      check("crc_hold", dout, cur);
      frame(2, 340, 9, 16'h0021, 1, 0, 0);
      check("short_err", 160'(err_cnt), 160'd2);
      frame(2, 340, 11, 16'h0031, 1, 0, 0);
      check("long_err", 160'(err_cnt), 160'd3);
      check("short_long_hold", dout, cur);
      frame(3, 340, 10, 16'h0041, 1, 0, 0);
      frame(2, 341, 10, 16'h0051, 1, 0, 0);
      check("wrong_slave_err", 160'(err_cnt), 160'd3);
      check("wrong_slave_hold", dout, cur);
      pulse(1, 0, 0, 0, 2, 340, 0);
      for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0, 0, 0, 16'h0EE0 + 16'(i));
      frame(2, 340, 10, 16'h0100, 1, 1, 0);
      check("abort_err", 160'(err_cnt), 160'd4);
      check("abort_data", dout, cur);
      frame(2, 340, 10, 16'h0200, 1, 1, 1);
      check("merge_data", dout, cur);
      check("merge_link_k0", 160'(link_ok), 160'd1);
      repeat (99) @(negedge clk);
      check("link_k99", 160'(link_ok), 160'd1);
      @(negedge clk);
      check("link_k100", 160'(link_ok), 160'd0);
      frame(2, 340, 10, 16'h0300, 1, 1, 0);
      check("link_restore", 160'(link_ok), 160'd1);
      pulse(1, 0, 0, 0, 2, 340, 0);
      for (int i = 0; i < 5; i++) pulse(0, 1, 0, 1, 0, 0, 16'h0400 + 16'(i));
      #2 reset_n = 1'b0;
      #2 check("async_reset_data", dout, '0);
      check("async_reset_err", 160'(err_cnt), 160'd0);
      check("async_reset_link", 160'(link_ok), 160'd0);
      cur = '0;
      @(negedge clk);
      reset_n = 1'b1;
      pulse(0, 1, 0, 1, 0, 0, 16'h0405);
      pulse(0, 0, 1, 1, 0, 0, 0);
      repeat (2) pulse(0, 0, 0, 0, 0, 0, 0);
      check("post_reset_data", dout, '0);
      check("post_reset_update", 160'(update), 160'd0);
      check("post_reset_err", 160'(err_cnt), 160'd0);
      frame(2, 340, 10, 16'h0500, 1, 1, 0);
      check("post_reset_good", dout, cur);
      for (int i = 0; i < 256; i++) begin
         pulse(1, 0, 0, 0, 2, 340, 0);
         pulse(0, 0, 1, 1, 0, 0, 0);
         pulse(0, 0, 0, 0, 0, 0, 0);
      end
      check("err_saturate", 160'(err_cnt), 160'd255);
      check("sat_hold", dout, cur);
      repeat (3) @(negedge clk);
      check("queue_drained", 160'(exp_q.size()), 160'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
